// File: rtl/ring_meas_pkg.sv
// Shared state encoding and default sizing for the ring oscillator frequency meter.
package ring_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } meas_state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_GATE_LOG2   = 10;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/ring_freq_meter_if.sv
// Control, readout and ring input signals of the frequency meter, bundled for the top-level port.
interface ring_freq_meter_if;

  logic       ring_in;
  logic       start;
  logic       cont;
  logic [1:0] byte_sel;
  logic [7:0] result_byte;
  logic       busy;
  logic       done;
  logic       overflow;

  modport master (
    output ring_in, start, cont, byte_sel,
    input  result_byte, busy, done, overflow
  );

  modport slave (
    input  ring_in, start, cont, byte_sel,
    output result_byte, busy, done, overflow
  );

endinterface

// File: rtl/ring_freq_meter_edge_sync.sv
// Brings the asynchronous ring output into the clk domain and emits a one-cycle pulse per rising edge.
module edge_sync
  import ring_meas_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  // r_prev free-runs so an edge landing on the first gate cycle is still seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/ring_freq_meter.sv
// Gated edge counter for ring oscillator characterisation; the latched count is read back a byte at a time.
module ring_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_LOG2   = DEF_GATE_LOG2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic              clk,
  input logic              rst,
  ring_freq_meter_if.slave bus
);

  localparam int NBYTES = CNT_W / 8;

  meas_state_t          r_state;
  logic [GATE_LOG2-1:0] r_gateCnt;
  logic [CNT_W-1:0]     r_edgeCnt;
  logic [CNT_W-1:0]     r_result;
  logic                 r_ovf;
  logic                 r_overflow;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_rise;
  logic                 w_gateLast;
  logic [7:0]           w_byte;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edgeSync (
    .clk    (clk),
    .rst    (rst),
    .i_async(bus.ring_in),
    .o_rise (w_rise)
  );

  assign w_gateLast = &r_gateCnt;

  // done is raised on the GATE->LATCH edge so it is high exactly during the LATCH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gateCnt  <= '0;
      r_edgeCnt  <= '0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= GATE;
            r_busy    <= 1'b1;
            r_gateCnt <= '0;
            r_edgeCnt <= '0;
            r_ovf     <= 1'b0;
          end
        end
        GATE: begin
          r_gateCnt <= r_gateCnt + GATE_LOG2'(1);
          if (w_rise) begin
            if (&r_edgeCnt) begin
              r_ovf <= 1'b1;
            end else begin
              r_edgeCnt <= r_edgeCnt + CNT_W'(1);
            end
          end
          if (w_gateLast) begin
            r_state <= LATCH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        LATCH: begin
          r_result   <= r_edgeCnt;
          r_overflow <= r_ovf;
          if (bus.cont) begin
            r_state   <= GATE;
            r_busy    <= 1'b1;
            r_gateCnt <= '0;
            r_edgeCnt <= '0;
            r_ovf     <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Byte selects beyond the result width read as zero.
  always_comb begin
    w_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (int'(bus.byte_sel) == k) begin
        w_byte = r_result[8*k +: 8];
      end
    end
  end

  assign bus.result_byte = w_byte;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: a 16-bit and an 8-bit instance share stimulus and are scored against an edge-count model.
module tb_ring_freq_meter;

  localparam int GATE_LEN = 1024;
  localparam int DET_LAT  = 3;
  localparam int WATCH    = 1100;
  localparam int PERIOD_C = GATE_LEN + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ringIn = 1'b0;
  logic       startIn = 1'b0;
  logic       contIn = 1'b0;
  logic [1:0] byteSel = 2'd0;
  int         cyc = 0;
  int         ringPer = 0;
  int         ringPh = 0;
  int         nCompared = 0;
  int         nFailed = 0;

  ring_freq_meter_if bus16 ();
  ring_freq_meter_if bus8 ();

  assign bus16.ring_in  = ringIn;
  assign bus16.start    = startIn;
  assign bus16.cont     = contIn;
  assign bus16.byte_sel = byteSel;
  assign bus8.ring_in   = ringIn;
  assign bus8.start     = startIn;
  assign bus8.cont      = contIn;
  assign bus8.byte_sel  = byteSel;

  ring_freq_meter #(.CNT_W(16), .GATE_LOG2(10), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16)
  );
  ring_freq_meter #(.CNT_W(8), .GATE_LOG2(10), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  always #5 clk = ~clk;

  // cyc holds the number of rising clk edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Ring waveform: the value driven here is the one sampled at rising edge number cyc+1.
  always @(negedge clk) ringIn = ringLevel(cyc + 1, ringPer, ringPh);

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic ringLevel(input int n, input int per, input int ph);
    if (per < 2) return 1'b0;
    return ((n + ph) % per) < (per / 2);
  endfunction

  // A rise sampled at edge n is counted at edge n+DET_LAT; gate edges are t+1 .. t+GATE_LEN.
  function automatic int modelCount(input int t, input int per, input int ph);
    int c = 0;
    for (int n = t + 1 - DET_LAT; n <= t + GATE_LEN - DET_LAT; n++) begin
      if (ringLevel(n, per, ph) && !ringLevel(n - 1, per, ph)) c++;
    end
    return c;
  endfunction

  task automatic setRing(input int per, input int ph);
    @(negedge clk);
    ringPer = per;
    ringPh  = ph;
    repeat (8) @(negedge clk);
  endtask

  // Pulses start once (plus optional extra pulses at the given gate offsets) and watches the gate.
  task automatic runGate(input int pulseA, input int pulseB, output int tStart,
                         output int busyLen, output int doneSeen, output int doneCyc);
    startIn  = 1'b1;
    tStart   = cyc + 1;
    busyLen  = 0;
    doneSeen = 0;
    doneCyc  = -1;
    for (int k = 0; k < WATCH; k++) begin
      @(negedge clk);
      startIn = ((cyc - tStart) == pulseA) || ((cyc - tStart) == pulseB);
      if (bus16.busy) busyLen++;
      if (bus16.done) begin
        doneSeen++;
        doneCyc = cyc;
      end
    end
    startIn = 1'b0;
  endtask

  task automatic readBack(output logic [23:0] r16, output logic ov16,
                          output logic [15:0] r8, output logic ov8);
    r16 = '0;
    r8  = '0;
    for (int b = 0; b < 3; b++) begin
      byteSel = 2'(b);
      #1;
      r16[8*b +: 8] = bus16.result_byte;
      if (b < 2) r8[8*b +: 8] = bus8.result_byte;
    end
    byteSel = 2'd0;
    ov16 = bus16.overflow;
    ov8  = bus8.overflow;
  endtask

  task automatic test_reset();
    int busyCnt = 0;
    int doneCnt = 0;
    rst     = 1'b1;
    ringPer = 6;
    ringPh  = 1;
    repeat (10) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      byteSel = 2'(b);
      #1;
      nCompared++;
      if ({bus16.busy, bus16.done, bus16.overflow, bus16.result_byte,
           bus8.busy, bus8.done, bus8.overflow, bus8.result_byte} !== 22'd0) begin
        nFailed++;
        $display("[TB] FAIL reset_outputs sel=%0d: got 16b busy=%b done=%b ovf=%b byte=%h, 8b busy=%b done=%b ovf=%b byte=%h, want all 0",
                 b, bus16.busy, bus16.done, bus16.overflow, bus16.result_byte,
                 bus8.busy, bus8.done, bus8.overflow, bus8.result_byte);
      end
    end
    byteSel = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (bus16.busy || bus8.busy) busyCnt++;
      if (bus16.done || bus8.done) doneCnt++;
    end
    nCompared++;
    if (busyCnt !== 0 || doneCnt !== 0) begin
      nFailed++;
      $display("[TB] FAIL idle_after_reset: busy cycles=%0d done pulses=%0d, want 0 and 0", busyCnt, doneCnt);
    end
  endtask

  task automatic test_nominal();
    int t, busyLen, doneSeen, doneCyc;
    logic [23:0] r16;
    logic [15:0] r8;
    logic ov16, ov8;
    setRing(16, 0);
    runGate(-1, -1, t, busyLen, doneSeen, doneCyc);
    readBack(r16, ov16, r8, ov8);
    nCompared++;
    if (busyLen !== GATE_LEN || doneSeen !== 1 || doneCyc !== t + GATE_LEN) begin
      nFailed++;
      $display("[TB] FAIL nominal_timing: busy=%0d dones=%0d done_at=+%0d, want busy=%0d dones=1 done_at=+%0d",
               busyLen, doneSeen, doneCyc - t, GATE_LEN, GATE_LEN);
    end
    nCompared++;
    if (r16 !== 24'h000040 || ov16 !== 1'b0) begin
      nFailed++;
      $display("[TB] FAIL nominal_bytes16: bytes2..0=%h ovf=%b, want 000040 ovf=0", r16, ov16);
    end
    nCompared++;
    if (r8 !== 16'h0040 || ov8 !== 1'b0) begin
      nFailed++;
      $display("[TB] FAIL nominal_bytes8: bytes1..0=%h ovf=%b, want 0040 ovf=0", r8, ov8);
    end
  endtask

  task automatic test_saturation();
    int t, busyLen, doneSeen, doneCyc, expCnt;
    logic [23:0] r16;
    logic [15:0] r8;
    logic ov16, ov8;
    setRing(4, 1);
    runGate(-1, -1, t, busyLen, doneSeen, doneCyc);
    readBack(r16, ov16, r8, ov8);
    expCnt = modelCount(t, 4, 1);
    nCompared++;
    if (r8 !== 16'h00FF || ov8 !== 1'b1) begin
      nFailed++;
      $display("[TB] FAIL saturate_8b: bytes1..0=%h ovf=%b, want 00ff ovf=1", r8, ov8);
    end
    nCompared++;
    if (r16 !== 24'(expCnt) || ov16 !== 1'b0) begin
      nFailed++;
      $display("[TB] FAIL saturate_16b: count=%h ovf=%b, want %h ovf=0", r16, ov16, 24'(expCnt));
    end
    setRing(16, 3);
    runGate(-1, -1, t, busyLen, doneSeen, doneCyc);
    readBack(r16, ov16, r8, ov8);
    nCompared++;
    if (r8 !== 16'h0040 || ov8 !== 1'b0) begin
      nFailed++;
      $display("[TB] FAIL after_saturate_8b: bytes1..0=%h ovf=%b, want 0040 ovf=0", r8, ov8);
    end
  endtask

  task automatic test_random();
    int t, busyLen, doneSeen, doneCyc, per, ph, expCnt;
    logic [23:0] r16;
    logic [15:0] r8;
    logic ov16, ov8;
    for (int i = 0; i < 6; i++) begin
      per = int'($urandom_range(60, 4));
      ph  = int'($urandom_range(per - 1, 0));
      setRing(per, ph);
      runGate(-1, -1, t, busyLen, doneSeen, doneCyc);
      readBack(r16, ov16, r8, ov8);
      expCnt = modelCount(t, per, ph);
      nCompared++;
      if (busyLen !== GATE_LEN || doneSeen !== 1 || doneCyc !== t + GATE_LEN) begin
        nFailed++;
        $display("[TB] FAIL random_timing per=%0d: busy=%0d dones=%0d done_at=+%0d, want %0d/1/+%0d",
                 per, busyLen, doneSeen, doneCyc - t, GATE_LEN, GATE_LEN);
      end
      nCompared++;
      if (r16 !== 24'(expCnt) || ov16 !== 1'b0 ||
          r8 !== 16'((expCnt > 255) ? 255 : expCnt) || ov8 !== (expCnt > 255)) begin
        nFailed++;
        $display("[TB] FAIL random_count per=%0d ph=%0d: r16=%h ovf16=%b r8=%h ovf8=%b, want count %0d",
                 per, ph, r16, ov16, r8, ov8, expCnt);
      end
    end
  endtask

  task automatic test_start_during_gate();
    int t, busyLen, doneSeen, doneCyc;
    logic [23:0] r16;
    logic [15:0] r8;
    logic ov16, ov8;
    setRing(20, 5);
    runGate(10, 500, t, busyLen, doneSeen, doneCyc);
    readBack(r16, ov16, r8, ov8);
    nCompared++;
    if (busyLen !== GATE_LEN || doneSeen !== 1 || doneCyc !== t + GATE_LEN) begin
      nFailed++;
      $display("[TB] FAIL start_in_gate_timing: busy=%0d dones=%0d done_at=+%0d, want %0d/1/+%0d",
               busyLen, doneSeen, doneCyc - t, GATE_LEN, GATE_LEN);
    end
    nCompared++;
    if (r16 !== 24'(modelCount(t, 20, 5))) begin
      nFailed++;
      $display("[TB] FAIL start_in_gate_count: got %h want %h", r16, 24'(modelCount(t, 20, 5)));
    end
  endtask

  task automatic test_continuous();
    int t, nDone, busyCnt, doneCnt;
    int doneAt[3];
    logic [7:0] res16At[3];
    logic [7:0] res8At[3];
    logic [23:0] r16;
    logic [15:0] r8;
    logic ov16, ov8;
    for (int i = 0; i < 3; i++) begin
      doneAt[i] = -1;
      res16At[i] = 8'hxx;
      res8At[i] = 8'hxx;
    end
    setRing(32, 7);
    contIn  = 1'b1;
    startIn = 1'b1;
    t       = cyc + 1;
    nDone   = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      startIn = 1'b0;
      if (nDone > 0 && cyc == doneAt[nDone-1] + 1) begin
        res16At[nDone-1] = bus16.result_byte;
        res8At[nDone-1]  = bus8.result_byte;
        if (nDone == 3) break;
      end
      if (nDone == 2 && cyc == doneAt[1] + 100) contIn = 1'b0;
      if (bus16.done && nDone < 3) begin
        doneAt[nDone] = cyc;
        nDone++;
      end
    end
    contIn = 1'b0;
    nCompared++;
    if (nDone !== 3 || doneAt[0] !== t + GATE_LEN ||
        doneAt[1] - doneAt[0] !== PERIOD_C || doneAt[2] - doneAt[1] !== PERIOD_C) begin
      nFailed++;
      $display("[TB] FAIL cont_spacing: dones=%0d first=+%0d gaps=%0d,%0d, want 3 +%0d %0d,%0d",
               nDone, doneAt[0] - t, doneAt[1] - doneAt[0], doneAt[2] - doneAt[1],
               GATE_LEN, PERIOD_C, PERIOD_C);
    end
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if (res16At[i] !== 8'(modelCount(t + i * PERIOD_C, 32, 7)) || res8At[i] !== 8'h20) begin
        nFailed++;
        $display("[TB] FAIL cont_result%0d: r16=%h r8=%h, want %h and 20",
                 i, res16At[i], res8At[i], 8'(modelCount(t + i * PERIOD_C, 32, 7)));
      end
    end
    busyCnt = 0;
    doneCnt = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (bus16.busy) busyCnt++;
      if (bus16.done) doneCnt++;
    end
    readBack(r16, ov16, r8, ov8);
    nCompared++;
    if (busyCnt !== 0 || doneCnt !== 0 || r16 !== 24'h000020) begin
      nFailed++;
      $display("[TB] FAIL cont_stop: busy cycles=%0d dones=%0d held=%h, want 0 0 000020", busyCnt, doneCnt, r16);
    end
  endtask

  task automatic test_reset_mid_gate();
    int t, busyLen, doneSeen, doneCyc, busyCnt, doneCnt;
    logic [23:0] r16;
    logic [15:0] r8;
    logic ov16, ov8;
    setRing(24, 2);
    startIn = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    startIn = 1'b0;
    while (cyc < t + 300) @(negedge clk);
    rst = 1'b1;
    #1;
    nCompared++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.result_byte !== 8'h00 ||
        bus16.overflow !== 1'b0 || bus8.busy !== 1'b0 || bus8.result_byte !== 8'h00) begin
      nFailed++;
      $display("[TB] FAIL reset_mid_gate: busy=%b done=%b byte=%h ovf=%b busy8=%b byte8=%h, want all 0",
               bus16.busy, bus16.done, bus16.result_byte, bus16.overflow, bus8.busy, bus8.result_byte);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    busyCnt = 0;
    doneCnt = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (bus16.busy) busyCnt++;
      if (bus16.done) doneCnt++;
    end
    nCompared++;
    if (busyCnt !== 0 || doneCnt !== 0) begin
      nFailed++;
      $display("[TB] FAIL after_mid_reset: busy cycles=%0d dones=%0d, want 0 0", busyCnt, doneCnt);
    end
    runGate(-1, -1, t, busyLen, doneSeen, doneCyc);
    readBack(r16, ov16, r8, ov8);
    nCompared++;
    if (busyLen !== GATE_LEN || doneSeen !== 1 || doneCyc !== t + GATE_LEN ||
        r16 !== 24'(modelCount(t, 24, 2)) || ov16 !== 1'b0) begin
      nFailed++;
      $display("[TB] FAIL restart: busy=%0d dones=%0d done_at=+%0d count=%h ovf=%b, want %0d 1 +%0d %h 0",
               busyLen, doneSeen, doneCyc - t, r16, ov16, GATE_LEN, GATE_LEN, 24'(modelCount(t, 24, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_random();
    test_start_during_gate();
    test_continuous();
    test_reset_mid_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Digital frequency meter for the on-chip ring oscillators: the reading end of the ring → driver path. It samples a ring output through a synchronizer and counts rising edges over a fixed gate window of clk cycles. The latched count is presented one byte at a time for readout over the dedicated digital outputs, so ring frequency can be characterised without an external frequency counter on the analog pins.

## Interface
Parameters:
- CNT_W, 16: edge-counter and result width; must be a multiple of 8.
- GATE_LOG2, 10: gate window is 2^GATE_LOG2 clk cycles.
- SYNC_STAGES, 2: flip-flops in the ring_in synchronizer; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ring_in  in  1  ring oscillator output, asynchronous to clk
- start  in  1  level; sampled in IDLE to begin one measurement
- cont  in  1  continuous mode: re-arm automatically after each measurement
- byte_sel  in  2  selects result byte for readout
- result_byte  out  8  result[8*byte_sel +: 8]; 0 if byte_sel ≥ CNT_W/8
- busy  out  1  high while gating
- done  out  1  one-cycle pulse when a new result is latched
- overflow  out  1  latched with result; 1 if the count saturated

## Operation
- FSM states: IDLE, GATE, LATCH.
- IDLE → GATE when start=1. Gate counter and edge counter clear on entry.
- GATE: gate counter increments every cycle. On each cycle with a detected rising edge, the edge counter increments, saturating at all-ones. Incrementing from all-ones sets the internal ovf flag. After 2^GATE_LOG2 GATE cycles → LATCH.
- LATCH (one cycle): result ← edge count, overflow ← ovf, done=1. Then → GATE if cont=1, else → IDLE.
- start and cont are ignored in GATE. cont is sampled only in LATCH.
- Edge detect: synchronized value is high and the previous synchronized value is low. The previous-value register runs continuously and is not cleared at gate start, so an edge detected in the first GATE cycle counts.
- Exact counting requires a ring_in period ≥ 4 clk. Faster inputs are undercounted; the block does not flag this. Rings are measured after external division.
- result_byte is a combinational mux of the result register and changes in the cycle after done.

## Timing
- Reset: state=IDLE, all counters 0, result=0, overflow=0, done=0, busy=0, result_byte=0.
- ring_in to edge detect: SYNC_STAGES+1 cycles.
- start sampled high in IDLE at cycle t: GATE spans t+1 … t+2^GATE_LOG2 with busy=1. LATCH/done at t+2^GATE_LOG2+1.
- Continuous mode: done period is 2^GATE_LOG2+1 cycles, with no idle gap.
- result and overflow hold until the next LATCH.
- rst asserted mid-GATE: immediate return to reset values. The partial count is discarded and no done pulse is issued.
- start held high through LATCH with cont=0: LATCH → IDLE, then a new GATE starts on the following cycle.

## Structure
- Package ring_meas_pkg holds:
  - state enum (IDLE, GATE, LATCH)
  - default CNT_W / GATE_LOG2 / SYNC_STAGES localparams
- Sub-module edge_sync contains the SYNC_STAGES synchronizer, the previous-value register and the rising-edge pulse output.
- FSM, counters, result register and byte mux sit in the top level.

## Test plan
- Reset: drive rst=1 with ring_in toggling → all outputs 0. After release with start=0 → busy stays 0 and no done pulse for 5000 cycles.
- Nominal: ring_in period 16 clk, phase-aligned, pulse start for 1 cycle → busy exactly 1024 cycles, done 1 cycle later, result=64, overflow=0. Bytes read: byte_sel=0 → 0x40, byte_sel=1 → 0x00, byte_sel=2 → 0x00.
- Saturation (CNT_W=8, GATE_LOG2=10): ring_in period 4 clk (256 edges) → result_byte=0xFF, overflow=1. Following run at period 16 → result=64, overflow=0.
- Start during GATE: pulse start at gate cycles 10 and 500 → exactly one done pulse, and busy length remains 1024.
- Continuous: cont=1, period 32 clk → done pulses exactly 1025 cycles apart, each with result=32. Drop cont before a LATCH → FSM returns to IDLE after that done.
- Reset mid-gate: assert rst at gate cycle 300 → busy=0 immediately, result=0, no done. A restart then yields the full 1024-cycle gate and the correct count.
